// File: rtl/wb_arbiter_pkg.sv
// Shared widths, LLU FIFO entry type and helpers for the write-back arbiter.
package wb_arbiter_pkg;

  localparam int unsigned RF_ADDR_WIDTH     = 5;
  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned RF_NUMBER         = 32;
  localparam int unsigned LLU_DEPTH_DEFAULT = 2;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [DATA_WIDTH-1:0]    rf_data_t;

  typedef struct packed {
    rf_addr_t rd;
    rf_data_t data;
  } llu_entry_t;

  // x0 is hard-wired zero, so a write to it is never architecturally visible.
  function automatic logic rd_writes(input rf_addr_t rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Pipeline <-> write-back arbiter <-> register file signal bundle.
// Forwarding outputs exist only when WB_FORWARD_EN is defined.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic     ret_valid;
  rf_addr_t ret_rd;
  rf_data_t ret_data;
  logic     ret_kill;

  logic     llu_issue;
  rf_addr_t llu_issue_rd;
  logic     llu_valid;
  logic     llu_ready;
  rf_addr_t llu_rd;
  rf_data_t llu_data;

  rf_addr_t chk_rs1, chk_rs2, chk_rs3;
  logic     chk_busy1, chk_busy2, chk_busy3;

  logic     wEN1;
  rf_addr_t wAddr1;
  rf_data_t wData1;
  logic     wEN2;
  rf_addr_t wAddr2;
  rf_data_t wData2;

`ifdef WB_FORWARD_EN
  logic     fwd_hit1, fwd_hit2, fwd_hit3;
  rf_data_t fwd_data1, fwd_data2, fwd_data3;

  modport master (
    output ret_valid, ret_rd, ret_data, ret_kill,
    output llu_issue, llu_issue_rd, llu_valid, llu_rd, llu_data,
    output chk_rs1, chk_rs2, chk_rs3,
    input  llu_ready, chk_busy1, chk_busy2, chk_busy3,
    input  wEN1, wAddr1, wData1, wEN2, wAddr2, wData2,
    input  fwd_hit1, fwd_hit2, fwd_hit3, fwd_data1, fwd_data2, fwd_data3
  );

  modport slave (
    input  ret_valid, ret_rd, ret_data, ret_kill,
    input  llu_issue, llu_issue_rd, llu_valid, llu_rd, llu_data,
    input  chk_rs1, chk_rs2, chk_rs3,
    output llu_ready, chk_busy1, chk_busy2, chk_busy3,
    output wEN1, wAddr1, wData1, wEN2, wAddr2, wData2,
    output fwd_hit1, fwd_hit2, fwd_hit3, fwd_data1, fwd_data2, fwd_data3
  );
`else
  modport master (
    output ret_valid, ret_rd, ret_data, ret_kill,
    output llu_issue, llu_issue_rd, llu_valid, llu_rd, llu_data,
    output chk_rs1, chk_rs2, chk_rs3,
    input  llu_ready, chk_busy1, chk_busy2, chk_busy3,
    input  wEN1, wAddr1, wData1, wEN2, wAddr2, wData2
  );

  modport slave (
    input  ret_valid, ret_rd, ret_data, ret_kill,
    input  llu_issue, llu_issue_rd, llu_valid, llu_rd, llu_data,
    input  chk_rs1, chk_rs2, chk_rs3,
    output llu_ready, chk_busy1, chk_busy2, chk_busy3,
    output wEN1, wAddr1, wData1, wEN2, wAddr2, wData2
  );
`endif

endinterface

// File: rtl/wb_llu_fifo.sv
// Synchronous FIFO of {rd, data} LLU results; head is read combinationally from storage.
module wb_llu_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = LLU_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  llu_entry_t push_entry_i,
  input  logic       pop_i,
  output llu_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  llu_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: registered retire on RF port 1, buffered LLU results on port 2,
// per-register busy scoreboard. WB_FORWARD_EN adds per-source forwarding outputs.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned LLU_DEPTH = LLU_DEPTH_DEFAULT
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  logic                 wen1_q, wen1_d;
  rf_addr_t             waddr1_q, waddr1_d;
  rf_data_t             wdata1_q, wdata1_d;
  logic [RF_NUMBER-1:0] busy_q, busy_d;

  llu_entry_t push_entry, head;
  logic       fifo_full, fifo_empty;
  logic       push, wen2, conflict;

  always_comb begin
    wen1_d   = bus.ret_valid & ~bus.ret_kill & rd_writes(bus.ret_rd);
    waddr1_d = waddr1_q;
    wdata1_d = wdata1_q;
    if (bus.ret_valid) begin
      waddr1_d = bus.ret_rd;
      wdata1_d = bus.ret_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen1_q   <= 1'b0;
      waddr1_q <= '0;
      wdata1_q <= '0;
      busy_q   <= '0;
    end else begin
      wen1_q   <= wen1_d;
      waddr1_q <= waddr1_d;
      wdata1_q <= wdata1_d;
      busy_q   <= busy_d;
    end
  end

  assign push_entry.rd   = bus.llu_rd;
  assign push_entry.data = bus.llu_data;
  assign push            = bus.llu_valid & ~fifo_full & rd_writes(bus.llu_rd);

  wb_llu_fifo #(
    .DEPTH(LLU_DEPTH)
  ) u_llu_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (wen2),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Hold the head while port 1 writes the same rd so the later-completing LLU value lands last.
  assign conflict = wen1_q & (waddr1_q == head.rd);
  assign wen2     = ~fifo_empty & ~conflict;

  always_comb begin
    busy_d = busy_q;
    if (wen2) busy_d[head.rd] = 1'b0;
    if (bus.llu_issue && rd_writes(bus.llu_issue_rd)) busy_d[bus.llu_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign bus.llu_ready = ~fifo_full;
  assign bus.wEN1      = wen1_q;
  assign bus.wAddr1    = waddr1_q;
  assign bus.wData1    = wdata1_q;
  assign bus.wEN2      = wen2;
  assign bus.wAddr2    = head.rd;
  assign bus.wData2    = head.data;

  rf_addr_t   chk_rs [3];
  logic [2:0] chk_busy;

  assign chk_rs[0] = bus.chk_rs1;
  assign chk_rs[1] = bus.chk_rs2;
  assign chk_rs[2] = bus.chk_rs3;

`ifdef WB_FORWARD_EN
  logic [2:0] fwd_hit;
  rf_data_t   fwd_data [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_chk
`ifdef WB_FORWARD_EN
    logic hit_p1, hit_p2;
    assign hit_p1       = wen1_q & (waddr1_q == chk_rs[g]) & rd_writes(chk_rs[g]);
    assign hit_p2       = wen2 & (head.rd == chk_rs[g]) & rd_writes(chk_rs[g]);
    assign fwd_hit[g]   = hit_p1 | hit_p2;
    assign fwd_data[g]  = hit_p1 ? wdata1_q : (hit_p2 ? head.data : '0);
    // A port-2 hit supplies the very value the scoreboard is waiting on.
    assign chk_busy[g]  = busy_q[chk_rs[g]] & ~(hit_p2 & ~hit_p1);
`else
    assign chk_busy[g]  = busy_q[chk_rs[g]];
`endif
  end

  assign bus.chk_busy1 = chk_busy[0];
  assign bus.chk_busy2 = chk_busy[1];
  assign bus.chk_busy3 = chk_busy[2];

`ifdef WB_FORWARD_EN
  assign bus.fwd_hit1  = fwd_hit[0];
  assign bus.fwd_hit2  = fwd_hit[1];
  assign bus.fwd_hit3  = fwd_hit[2];
  assign bus.fwd_data1 = fwd_data[0];
  assign bus.fwd_data2 = fwd_data[1];
  assign bus.fwd_data3 = fwd_data[2];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: scoreboard queues for both RF write ports plus point checks.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter #(.LLU_DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  llu_entry_t exp_p1[$];
  llu_entry_t exp_p2[$];
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic llu_entry_t mk(input rf_addr_t rd, input rf_data_t d);
    llu_entry_t e;
    e.rd = rd;
    e.data = d;
    return e;
  endfunction

  // Port writes are compared against the expected queues as they happen.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (bus.wEN1 !== 1'b0) begin
        if (exp_p1.size() == 0) check("p1_unexpected_write", 64'(bus.wEN1), 64'd0);
        else check("p1_write", 64'({bus.wAddr1, bus.wData1}), 64'(exp_p1.pop_front()));
      end
      if (bus.wEN2 !== 1'b0) begin
        if (exp_p2.size() == 0) check("p2_unexpected_write", 64'(bus.wEN2), 64'd0);
        else check("p2_write", 64'({bus.wAddr2, bus.wData2}), 64'(exp_p2.pop_front()));
      end
    end
  end

  task automatic llu_send(input rf_addr_t rd, input rf_data_t d);
    int unsigned n;
    logic acc;
    n = 0;
    bus.llu_valid = 1'b1;
    bus.llu_rd = rd;
    bus.llu_data = d;
    if (rd != '0) exp_p2.push_back(mk(rd, d));
    do begin
      acc = bus.llu_ready;
      step();
      n++;
    end while (!acc && n < 20);
    if (!acc) check("llu_accept_timeout", 64'(acc), 64'd1);
    bus.llu_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (exp_p1.size() != 0 || exp_p2.size() != 0); i++) step();
    check("drain_p1_pending", 64'(exp_p1.size()), 64'd0);
    check("drain_p2_pending", 64'(exp_p2.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t limit=100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_busy_during_write;
    int unsigned n;
    logic acc;

    bus.ret_valid = 0; bus.ret_rd = 0; bus.ret_data = 0; bus.ret_kill = 0;
    bus.llu_issue = 0; bus.llu_issue_rd = 0;
    bus.llu_valid = 0; bus.llu_rd = 0; bus.llu_data = 0;
    bus.chk_rs1 = 0; bus.chk_rs2 = 0; bus.chk_rs3 = 0;

    #3;
    check("rst_wen1", 64'(bus.wEN1), 64'd0);
    check("rst_wen2", 64'(bus.wEN2), 64'd0);
    check("rst_ready", 64'(bus.llu_ready), 64'd1);
    check("rst_waddr2", 64'(bus.wAddr2), 64'd0);
    check("rst_wdata1", 64'(bus.wData1), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // Port 1: normal, killed, rd=0, hold
    bus.ret_valid = 1; bus.ret_rd = 3; bus.ret_data = 32'hDEAD; bus.ret_kill = 0;
    exp_p1.push_back(mk(5'd3, 32'hDEAD));
    step();
    check("ret_wen1", 64'(bus.wEN1), 64'd1);
    check("ret_waddr1", 64'(bus.wAddr1), 64'd3);
    check("ret_wdata1", 64'(bus.wData1), 64'hDEAD);
    bus.ret_kill = 1; bus.ret_data = 32'hBEEF;
    step();
    check("kill_wen1", 64'(bus.wEN1), 64'd0);
    check("kill_wdata1_loaded", 64'(bus.wData1), 64'hBEEF);
    bus.ret_kill = 0; bus.ret_rd = 0; bus.ret_data = 32'h55;
    step();
    check("rd0_wen1", 64'(bus.wEN1), 64'd0);
    bus.ret_valid = 0; bus.ret_rd = 3; bus.ret_data = 32'h77;
    step();
    check("hold_waddr1", 64'(bus.wAddr1), 64'd0);
    check("hold_wdata1", 64'(bus.wData1), 64'h55);

    // Scoreboard for x7
    bus.chk_rs1 = 7; bus.chk_rs3 = 8;
    bus.llu_issue = 1; bus.llu_issue_rd = 7;
    check("busy7_before_issue", 64'(bus.chk_busy1), 64'd0);
    step();
    bus.llu_issue = 0;
    check("busy7_after_issue", 64'(bus.chk_busy1), 64'd1);
    check("busy8_untouched", 64'(bus.chk_busy3), 64'd0);
    step(); step();
    check("busy7_held", 64'(bus.chk_busy1), 64'd1);
    llu_send(5'd7, 32'h1234);
    check("p2_wen_next_cycle", 64'(bus.wEN2), 64'd1);
    check("p2_waddr", 64'(bus.wAddr2), 64'd7);
`ifdef WB_FORWARD_EN
    exp_busy_during_write = 1'b0;
`else
    exp_busy_during_write = 1'b1;
`endif
    check("busy7_during_write", 64'(bus.chk_busy1), 64'(exp_busy_during_write));
    step();
    check("busy7_cleared", 64'(bus.chk_busy1), 64'd0);
    check("p2_idle", 64'(bus.wEN2), 64'd0);

    // rd=0 LLU result is accepted and dropped
    llu_send(5'd0, 32'h99);
    check("llu_rd0_dropped", 64'(bus.wEN2), 64'd0);
    check("llu_rd0_ready", 64'(bus.llu_ready), 64'd1);

    // Three results into a depth-2 FIFO with the head held by conflict
    bus.ret_valid = 1; bus.ret_rd = 10; bus.ret_data = 32'h100;
    exp_p1.push_back(mk(5'd10, 32'h100));
    bus.llu_valid = 1; bus.llu_rd = 10; bus.llu_data = 32'hA1;
    exp_p2.push_back(mk(5'd10, 32'hA1));
    exp_p2.push_back(mk(5'd10, 32'hA2));
    exp_p2.push_back(mk(5'd10, 32'hA3));
    step();
    check("conf_wen2_blocked", 64'(bus.wEN2), 64'd0);
    check("conf_ready_second", 64'(bus.llu_ready), 64'd1);
    bus.ret_data = 32'h101; exp_p1.push_back(mk(5'd10, 32'h101));
    bus.llu_data = 32'hA2;
    step();
    bus.ret_data = 32'h102; exp_p1.push_back(mk(5'd10, 32'h102));
    bus.llu_data = 32'hA3;
    check("conf_third_blocked", 64'(bus.llu_ready), 64'd0);
    check("conf_wen2_still_blocked", 64'(bus.wEN2), 64'd0);
    step();
    bus.ret_valid = 0;
    check("conf_still_full", 64'(bus.llu_ready), 64'd0);
    n = 0;
    do begin
      acc = bus.llu_ready;
      step();
      n++;
    end while (!acc && n < 20);
    if (!acc) check("conf_third_timeout", 64'(acc), 64'd1);
    bus.llu_valid = 0;
    drain();

    // Same-edge clear of x9 and new issue of x9: set wins
    bus.chk_rs2 = 9;
    bus.llu_issue = 1; bus.llu_issue_rd = 9;
    step();
    bus.llu_issue = 0;
    check("busy9_set", 64'(bus.chk_busy2), 64'd1);
    llu_send(5'd9, 32'h900);
    check("x9_p2_write", 64'(bus.wEN2), 64'd1);
    bus.llu_issue = 1; bus.llu_issue_rd = 9;
    step();
    bus.llu_issue = 0;
    check("x9_set_wins", 64'(bus.chk_busy2), 64'd1);
    step();
    check("x9_still_busy", 64'(bus.chk_busy2), 64'd1);
    llu_send(5'd9, 32'h901);
    step();
    check("x9_cleared", 64'(bus.chk_busy2), 64'd0);

`ifdef WB_FORWARD_EN
    // Port-1 forwarding has priority; port-2 hit masks busy
    bus.chk_rs1 = 4;
    bus.llu_issue = 1; bus.llu_issue_rd = 4;
    step();
    bus.llu_issue = 0;
    bus.ret_valid = 1; bus.ret_rd = 4; bus.ret_data = 32'hA;
    exp_p1.push_back(mk(5'd4, 32'hA));
    bus.llu_valid = 1; bus.llu_rd = 4; bus.llu_data = 32'hB;
    exp_p2.push_back(mk(5'd4, 32'hB));
    step();
    bus.ret_valid = 0; bus.llu_valid = 0;
    check("fwd_hit1_p1", 64'(bus.fwd_hit1), 64'd1);
    check("fwd_data1_p1", 64'(bus.fwd_data1), 64'hA);
    check("fwd_busy1_p1", 64'(bus.chk_busy1), 64'd1);
    step();
    check("fwd_hit1_p2", 64'(bus.fwd_hit1), 64'd1);
    check("fwd_data1_p2", 64'(bus.fwd_data1), 64'hB);
    check("fwd_busy1_masked", 64'(bus.chk_busy1), 64'd0);
    step();
    check("fwd_hit1_idle", 64'(bus.fwd_hit1), 64'd0);
    check("fwd_data1_idle", 64'(bus.fwd_data1), 64'd0);
    drain();
`endif

    // Reset mid-operation: two buffered entries, busy[5] set
    bus.chk_rs3 = 5;
    bus.llu_issue = 1; bus.llu_issue_rd = 5;
    step();
    bus.llu_issue = 0;
    bus.ret_valid = 1; bus.ret_rd = 11; bus.ret_data = 32'h200;
    exp_p1.push_back(mk(5'd11, 32'h200));
    bus.llu_valid = 1; bus.llu_rd = 11; bus.llu_data = 32'h300;
    exp_p2.push_back(mk(5'd11, 32'h300));
    step();
    bus.ret_data = 32'h201; exp_p1.push_back(mk(5'd11, 32'h201));
    bus.llu_data = 32'h301; exp_p2.push_back(mk(5'd11, 32'h301));
    step();
    bus.llu_valid = 0;
    check("prerst_full", 64'(bus.llu_ready), 64'd0);
    check("prerst_busy5", 64'(bus.chk_busy3), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_wen2", 64'(bus.wEN2), 64'd0);
    check("midrst_ready", 64'(bus.llu_ready), 64'd1);
    check("midrst_busy5", 64'(bus.chk_busy3), 64'd0);
    check("midrst_wen1", 64'(bus.wEN1), 64'd0);
    check("midrst_waddr2", 64'(bus.wAddr2), 64'd0);
    check("midrst_wdata1", 64'(bus.wData1), 64'd0);
    exp_p1.delete();
    exp_p2.delete();
    bus.ret_valid = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    check("postrst_wen2", 64'(bus.wEN2), 64'd0);

    // Post-reset sanity on both ports
    bus.ret_valid = 1; bus.ret_rd = 3; bus.ret_data = 32'h1;
    exp_p1.push_back(mk(5'd3, 32'h1));
    step();
    bus.ret_valid = 0;
    check("postrst_wen1", 64'(bus.wEN1), 64'd1);
    llu_send(5'd12, 32'hC);
    check("postrst_p2_addr", 64'(bus.wAddr2), 64'd12);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
